// File: rtl/game_step_sequencer.sv
// Tetris step sequencer: spawns, drops, moves, locks and clears the active
// piece by issuing one-cycle strobes to the board datapath.
package tetris_pkg;
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_ROTATE,
        CMD_DOWN,
        CMD_DROP,
        CMD_HOLD,
        CMD_PAUSE
    } command_t;
endpackage

module game_step_sequencer
    import tetris_pkg::*;
#(
    parameter int LOCK_TICKS = 1,
    parameter int LINES_W    = 16,
    parameter int PIECES_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                game_tick,
    input  logic                move_valid,
    input  command_t            move,
    input  logic                left_collision,
    input  logic                right_collision,
    input  logic                down_collision,
    input  logic                rotation_collision,
    input  logic                spawn_collision,
    input  logic                any_full_row,
    input  logic                restart,
    output logic                spawn_en,
    output logic                drop_en,
    output logic                left_en,
    output logic                right_en,
    output logic                rotate_en,
    output logic                lock_en,
    output logic                clear_en,
    output logic                board_clear_en,
    output logic                no_piece,
    output logic                game_over,
    output logic                busy,
    output logic [LINES_W-1:0]  lines_cleared,
    output logic [PIECES_W-1:0] pieces_placed
);

    typedef enum logic [2:0] {
        SPAWN,
        SPAWN_CHK,
        PLAY,
        SETTLE,
        LOCK,
        CLR_CHK,
        CLEAR,
        OVER
    } state_t;

    localparam int CW = $clog2(LOCK_TICKS + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   lock_cnt, lock_cnt_nx, lock_inc;
    logic            tick_pend, tick_pend_nx;
    command_t        mv, mv_nx;
    logic            drop_q, left_q, right_q, rotate_q, bclr_q;
    logic            drop_nx, left_nx, right_nx, rotate_nx, bclr_nx;
    logic            lines_inc, pieces_inc, cnt_zero;
    logic            move_ok, tick_eff, move_issue;
    logic [LINES_W-1:0]  lines_q;
    logic [PIECES_W-1:0] pieces_q;

    assign move_ok  = move_valid &&
                      (move == CMD_LEFT || move == CMD_RIGHT ||
                       move == CMD_ROTATE);
    assign tick_eff = game_tick | tick_pend;
    assign lock_inc = lock_cnt + CW'(1);

    always_comb begin
        state_nx     = state;
        lock_cnt_nx  = lock_cnt;
        tick_pend_nx = tick_pend;
        mv_nx        = move_ok ? move : mv;
        drop_nx      = 1'b0;
        left_nx      = 1'b0;
        right_nx     = 1'b0;
        rotate_nx    = 1'b0;
        bclr_nx      = 1'b0;
        lines_inc    = 1'b0;
        pieces_inc   = 1'b0;
        cnt_zero     = 1'b0;
        move_issue   = 1'b0;
        unique case (state)
            SPAWN: begin
                mv_nx = CMD_NONE;
                // hold one extra cycle while the board clear strobe is out
                if (!bclr_q)
                    state_nx = SPAWN_CHK;
            end
            SPAWN_CHK: begin
                if (game_tick)
                    tick_pend_nx = 1'b1;
                state_nx = spawn_collision ? OVER : PLAY;
            end
            PLAY: begin
                tick_pend_nx = 1'b0;
                if (!down_collision)
                    lock_cnt_nx = '0;
                if (tick_eff) begin
                    if (!down_collision) begin
                        drop_nx  = 1'b1;
                        state_nx = SETTLE;
                    end else if (lock_inc == CW'(LOCK_TICKS)) begin
                        state_nx = LOCK;
                    end else begin
                        lock_cnt_nx = lock_inc;
                    end
                end else if (mv != CMD_NONE) begin
                    left_nx    = (mv == CMD_LEFT) && !left_collision;
                    right_nx   = (mv == CMD_RIGHT) && !right_collision;
                    rotate_nx  = (mv == CMD_ROTATE) && !rotation_collision;
                    move_issue = left_nx | right_nx | rotate_nx;
                    mv_nx      = move_ok ? move : CMD_NONE;
                    if (move_issue)
                        state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (game_tick)
                    tick_pend_nx = 1'b1;
                state_nx = PLAY;
            end
            LOCK: begin
                lock_cnt_nx = '0;
                pieces_inc  = 1'b1;
                state_nx    = CLR_CHK;
            end
            CLR_CHK: begin
                if (game_tick)
                    tick_pend_nx = 1'b1;
                state_nx = any_full_row ? CLEAR : SPAWN;
            end
            CLEAR: begin
                lines_inc = 1'b1;
                state_nx  = CLR_CHK;
            end
            OVER: begin
                mv_nx        = CMD_NONE;
                tick_pend_nx = 1'b0;
                if (restart) begin
                    bclr_nx     = 1'b1;
                    cnt_zero    = 1'b1;
                    lock_cnt_nx = '0;
                    state_nx    = SPAWN;
                end
            end
            default: state_nx = SPAWN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SPAWN;
            lock_cnt  <= '0;
            tick_pend <= 1'b0;
            mv        <= CMD_NONE;
            drop_q    <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            rotate_q  <= 1'b0;
            bclr_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            lock_cnt  <= lock_cnt_nx;
            tick_pend <= tick_pend_nx;
            mv        <= mv_nx;
            drop_q    <= drop_nx;
            left_q    <= left_nx;
            right_q   <= right_nx;
            rotate_q  <= rotate_nx;
            bclr_q    <= bclr_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_q  <= '0;
            pieces_q <= '0;
        end else if (cnt_zero) begin
            lines_q  <= '0;
            pieces_q <= '0;
        end else begin
            if (lines_inc && lines_q != '1)
                lines_q <= lines_q + LINES_W'(1);
            if (pieces_inc && pieces_q != '1)
                pieces_q <= pieces_q + PIECES_W'(1);
        end
    end

    // spawn is decoded from state, so mask it while reset holds state at SPAWN
    assign spawn_en       = (state == SPAWN) && !bclr_q && !reset;
    assign drop_en        = drop_q;
    assign left_en        = left_q;
    assign right_en       = right_q;
    assign rotate_en      = rotate_q;
    assign lock_en        = (state == LOCK);
    assign clear_en       = (state == CLEAR);
    assign board_clear_en = bclr_q;
    assign no_piece       = !(state == PLAY || state == SETTLE);
    assign game_over      = (state == OVER);
    assign busy           = (state != PLAY);
    assign lines_cleared  = lines_q;
    assign pieces_placed  = pieces_q;

endmodule

// File: tb/tb_game_step_sequencer.sv
// Bench for game_step_sequencer: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference.
module tb_game_step_sequencer;
    import tetris_pkg::*;

    localparam int LT = 2;
    localparam logic [7:0] S_SPAWN = 8'h01;
    localparam logic [7:0] S_DROP  = 8'h02;
    localparam logic [7:0] S_LEFT  = 8'h04;
    localparam logic [7:0] S_RIGHT = 8'h08;
    localparam logic [7:0] S_ROT   = 8'h10;
    localparam logic [7:0] S_LOCK  = 8'h20;
    localparam logic [7:0] S_CLEAR = 8'h40;
    localparam logic [7:0] S_BCLR  = 8'h80;
    localparam logic [3:0] CL = 4'b0001;
    localparam logic [3:0] CR = 4'b0010;
    localparam logic [3:0] CD = 4'b0100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic game_tick = 1'b0, move_valid = 1'b0;
    command_t move = CMD_NONE;
    logic left_collision = 1'b0, right_collision = 1'b0;
    logic down_collision = 1'b0, rotation_collision = 1'b0;
    logic spawn_collision = 1'b0, any_full_row = 1'b0, restart = 1'b0;
    logic spawn_en, drop_en, left_en, right_en, rotate_en;
    logic lock_en, clear_en, board_clear_en;
    logic no_piece, game_over, busy;
    logic [15:0] lines_cleared, pieces_placed;

    int checks = 0;
    int failures = 0;

    game_step_sequencer #(
        .LOCK_TICKS(LT),
        .LINES_W(16),
        .PIECES_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .game_tick(game_tick),
        .move_valid(move_valid),
        .move(move),
        .left_collision(left_collision),
        .right_collision(right_collision),
        .down_collision(down_collision),
        .rotation_collision(rotation_collision),
        .spawn_collision(spawn_collision),
        .any_full_row(any_full_row),
        .restart(restart),
        .spawn_en(spawn_en),
        .drop_en(drop_en),
        .left_en(left_en),
        .right_en(right_en),
        .rotate_en(rotate_en),
        .lock_en(lock_en),
        .clear_en(clear_en),
        .board_clear_en(board_clear_en),
        .no_piece(no_piece),
        .game_over(game_over),
        .busy(busy),
        .lines_cleared(lines_cleared),
        .pieces_placed(pieces_placed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       mvv;
        command_t   cmd;
        logic [3:0] col;
        logic [7:0] str;
        logic       bsy;
        logic       np;
    } vec_t;

    typedef struct packed {
        logic [7:0] str;
        logic       bsy;
        logic       np;
        logic       latch;
        logic       flush;
        logic       lock;
    } item_t;

    vec_t  tv [26];
    item_t mq [$];
    logic        m_tp;
    command_t    m_mv;
    int          m_lc;
    logic [15:0] m_pieces;

    function automatic logic [7:0] strobes();
        return {board_clear_en, clear_en, lock_en, rotate_en,
                right_en, left_en, drop_en, spawn_en};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic t, input logic mvv, input command_t c,
                         input logic [3:0] col);
        game_tick          = t;
        move_valid         = mvv;
        move               = c;
        left_collision     = col[0];
        right_collision    = col[1];
        down_collision     = col[2];
        rotation_collision = col[3];
    endtask

    // one clock cycle: drive, check strobes mid-cycle, advance to edge+1
    task automatic cyc(input logic t, input logic mvv, input command_t c,
                       input logic [3:0] col, input logic sc,
                       input logic afr, input logic rs,
                       input logic [7:0] es, input string nm);
        drive(t, mvv, c, col);
        spawn_collision = sc;
        any_full_row    = afr;
        restart         = rs;
        @(negedge clk);
        chk(nm, 32'(strobes()), 32'(es));
        @(posedge clk);
        #1;
        game_tick  = 1'b0;
        move_valid = 1'b0;
        restart    = 1'b0;
    endtask

    function automatic item_t mk(input logic [7:0] s, input logic b,
                                 input logic n, input logic la,
                                 input logic fl, input logic lk);
        item_t it;
        it.str   = s;
        it.bsy   = b;
        it.np    = n;
        it.latch = la;
        it.flush = fl;
        it.lock  = lk;
        return it;
    endfunction

    function automatic logic valid_cmd(input command_t c);
        return c == CMD_LEFT || c == CMD_RIGHT || c == CMD_ROTATE;
    endfunction

    // reference: non-play cycles are scripted as a queue of upcoming
    // cycles; an empty queue means the piece is in free play
    task automatic model_step(input logic t, input logic mvv,
                              input command_t c, input logic [3:0] col);
        item_t it;
        logic blk;
        logic [7:0] s;
        if (mq.size() != 0) begin
            it = mq.pop_front();
            if (it.latch && t) m_tp = 1'b1;
            if (it.lock && m_pieces != 16'hffff) m_pieces++;
            if (mvv && valid_cmd(c)) m_mv = c;
            if (it.flush) m_mv = CMD_NONE;
        end else begin
            logic teff;
            teff = t | m_tp;
            m_tp = 1'b0;
            if (!col[2]) m_lc = 0;
            if (teff) begin
                if (!col[2]) begin
                    mq.push_back(mk(S_DROP, 1, 0, 1, 0, 0));
                end else begin
                    m_lc++;
                    if (m_lc == LT) begin
                        m_lc = 0;
                        mq.push_back(mk(S_LOCK, 1, 1, 0, 0, 1));
                        mq.push_back(mk(8'h00, 1, 1, 1, 0, 0));
                        mq.push_back(mk(S_SPAWN, 1, 1, 0, 1, 0));
                        mq.push_back(mk(8'h00, 1, 1, 1, 0, 0));
                    end
                end
            end else if (m_mv != CMD_NONE) begin
                blk = (m_mv == CMD_LEFT)  ? col[0] :
                      (m_mv == CMD_RIGHT) ? col[1] : col[3];
                s   = (m_mv == CMD_LEFT)  ? S_LEFT :
                      (m_mv == CMD_RIGHT) ? S_RIGHT : S_ROT;
                if (!blk) mq.push_back(mk(s, 1, 0, 1, 0, 0));
                m_mv = CMD_NONE;
            end
            if (mvv && valid_cmd(c)) m_mv = c;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, CMD_NONE, 4'h0);
        spawn_collision = 1'b0;
        any_full_row    = 1'b0;
        restart         = 1'b0;
        reset           = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        tv[0]  = '{0, 0, CMD_NONE,   4'h0, S_SPAWN, 1, 1};
        tv[1]  = '{0, 0, CMD_NONE,   4'h0, 8'h00,   1, 1};
        tv[2]  = '{1, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[3]  = '{0, 0, CMD_NONE,   4'h0, S_DROP,  1, 0};
        tv[4]  = '{1, 1, CMD_LEFT,   4'h0, 8'h00,   0, 0};
        tv[5]  = '{0, 0, CMD_NONE,   4'h0, S_DROP,  1, 0};
        tv[6]  = '{0, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[7]  = '{0, 0, CMD_NONE,   4'h0, S_LEFT,  1, 0};
        tv[8]  = '{0, 1, CMD_RIGHT,  CR,   8'h00,   0, 0};
        tv[9]  = '{0, 0, CMD_NONE,   CR,   8'h00,   0, 0};
        tv[10] = '{0, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[11] = '{0, 1, CMD_ROTATE, 4'h0, 8'h00,   0, 0};
        tv[12] = '{0, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[13] = '{0, 0, CMD_NONE,   4'h0, S_ROT,   1, 0};
        tv[14] = '{0, 1, CMD_DOWN,   4'h0, 8'h00,   0, 0};
        tv[15] = '{0, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[16] = '{0, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[17] = '{1, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[18] = '{1, 0, CMD_NONE,   4'h0, S_DROP,  1, 0};
        tv[19] = '{0, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[20] = '{0, 0, CMD_NONE,   4'h0, S_DROP,  1, 0};
        tv[21] = '{0, 0, CMD_NONE,   4'h0, 8'h00,   0, 0};
        tv[22] = '{1, 1, CMD_LEFT,   CL,   8'h00,   0, 0};
        tv[23] = '{0, 0, CMD_NONE,   CL,   S_DROP,  1, 0};
        tv[24] = '{0, 0, CMD_NONE,   CL,   8'h00,   0, 0};
        tv[25] = '{0, 0, CMD_NONE,   CL,   8'h00,   0, 0};

        #3;
        chk("reset_strobes", 32'(strobes()), 32'h0);
        chk("reset_flags", {29'h0, busy, no_piece, game_over}, 32'b110);
        chk("reset_counters", {lines_cleared, pieces_placed}, 32'h0);
        do_reset();

        for (int i = 0; i < 26; i++) begin
            drive(tv[i].tick, tv[i].mvv, tv[i].cmd, tv[i].col);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {22'h0, strobes(), busy, no_piece},
                {22'h0, tv[i].str, tv[i].bsy, tv[i].np});
            @(posedge clk);
            #1;
        end

        cyc(1, 0, CMD_NONE, CD, 0, 0, 0, 8'h00, "lock_tick1");
        chk("lock_hold_play", 32'(busy), 32'h0);
        cyc(0, 0, CMD_NONE, 4'h0, 0, 0, 0, 8'h00, "slide_off");
        cyc(1, 0, CMD_NONE, CD, 0, 0, 0, 8'h00, "lock_restart");
        cyc(1, 0, CMD_NONE, CD, 0, 0, 0, 8'h00, "lock_tick2");
        cyc(0, 0, CMD_NONE, CD, 0, 0, 0, S_LOCK, "lock_en");
        cyc(0, 0, CMD_NONE, CD, 0, 1, 0, 8'h00, "clr_chk1");
        chk("pieces_one", 32'(pieces_placed), 32'd1);
        cyc(0, 0, CMD_NONE, CD, 0, 1, 0, S_CLEAR, "clear1");
        cyc(0, 0, CMD_NONE, CD, 0, 1, 0, 8'h00, "clr_chk2");
        cyc(0, 0, CMD_NONE, CD, 0, 1, 0, S_CLEAR, "clear2");
        cyc(0, 0, CMD_NONE, CD, 0, 1, 0, 8'h00, "clr_chk3");
        cyc(0, 0, CMD_NONE, CD, 0, 1, 0, S_CLEAR, "clear3");
        cyc(0, 0, CMD_NONE, CD, 0, 0, 0, 8'h00, "clr_chk_done");
        chk("lines_three", 32'(lines_cleared), 32'd3);
        cyc(0, 0, CMD_NONE, 4'h0, 0, 0, 0, S_SPAWN, "respawn");
        cyc(0, 0, CMD_NONE, 4'h0, 1, 0, 0, 8'h00, "spawn_chk_over");
        chk("over_flags", {30'h0, game_over, no_piece}, 32'b11);
        cyc(1, 1, CMD_LEFT, 4'h0, 0, 0, 0, 8'h00, "over_tick_move");
        cyc(0, 1, CMD_ROTATE, 4'h0, 0, 0, 0, 8'h00, "over_idle");
        cyc(0, 0, CMD_NONE, 4'h0, 0, 0, 1, 8'h00, "over_restart");
        cyc(0, 0, CMD_NONE, 4'h0, 0, 0, 0, S_BCLR, "board_clear");
        chk("restart_counters", {lines_cleared, pieces_placed}, 32'h0);
        chk("restart_over_low", 32'(game_over), 32'h0);
        cyc(0, 0, CMD_NONE, 4'h0, 0, 0, 0, S_SPAWN, "spawn_after_restart");
        cyc(0, 0, CMD_NONE, 4'h0, 0, 0, 0, 8'h00, "spawn_chk_ok");
        chk("play_after_restart", 32'(busy), 32'h0);

        cyc(1, 0, CMD_NONE, CD, 0, 0, 0, 8'h00, "r_tick1");
        cyc(1, 0, CMD_NONE, CD, 0, 0, 0, 8'h00, "r_tick2");
        cyc(0, 0, CMD_NONE, CD, 0, 0, 0, S_LOCK, "r_lock");
        cyc(0, 0, CMD_NONE, CD, 0, 1, 0, 8'h00, "r_clr_chk");
        chk("pre_reset_clear", 32'(strobes()), 32'(S_CLEAR));
        #2 reset = 1'b1;
        #1;
        chk("async_strobes", 32'(strobes()), 32'h0);
        chk("async_flags", {29'h0, busy, no_piece, game_over}, 32'b110);
        chk("async_counters", {lines_cleared, pieces_placed}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        any_full_row = 1'b0;
        drive(0, 0, CMD_NONE, 4'h0);
        reset = 1'b0;
        #1;
        chk("spawn_after_reset", 32'(strobes()), 32'(S_SPAWN));
        @(posedge clk);
        #1;

        do_reset();
        mq.delete();
        mq.push_back(mk(S_SPAWN, 1, 1, 0, 1, 0));
        mq.push_back(mk(8'h00, 1, 1, 1, 0, 0));
        m_tp = 1'b0;
        m_mv = CMD_NONE;
        m_lc = 0;
        m_pieces = 16'h0;
        for (int k = 0; k < 800; k++) begin
            logic t, mvv;
            logic [2:0] cr;
            logic [3:0] col;
            item_t e;
            t   = ($urandom_range(0, 4) == 0);
            mvv = ($urandom_range(0, 2) == 0);
            cr  = 3'($urandom_range(0, 7));
            col = 4'($urandom_range(0, 15));
            col[2] = ($urandom_range(0, 2) == 0);
            drive(t, mvv, command_t'(cr), col);
            e = (mq.size() != 0) ? mq[0] : mk(8'h00, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("rand%0d", k),
                {6'h0, strobes(), busy, no_piece, pieces_placed},
                {6'h0, e.str, e.bsy, e.np, m_pieces});
            model_step(t, mvv, command_t'(cr), col);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
